xrv1_tcm_arb: RTL and testbench
===============================

Name: xrv1_tcm_arb

Overview:
Two-requester arbiter sharing the single data port of the simulation TCM between the core LSU (m0) and a debug/program-loader master (m1). Round-robin grant on the request channel. An in-order ID FIFO routes each returning response to the master that issued it. Sits between the core/loader and the TCM data port; the instruction port is not arbitrated.

Parameters:
outst_depth_p, 4, max accepted-but-unanswered requests (power of 2, >=2)
outst_cnt_width_lp, $clog2(outst_depth_p+1), occupancy counter width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_req_vld_i / m1_req_vld_i  in  1  request valid, per master
m0_req_rdy_o / m1_req_rdy_o  out  1  request accepted this cycle
m0_req_addr_i / m1_req_addr_i  in  32  byte address
m0_req_w_en_i / m1_req_w_en_i  in  1  write enable
m0_req_w_be_i / m1_req_w_be_i  in  4  byte enables
m0_req_w_data_i / m1_req_w_data_i  in  32  write data
m0_resp_vld_o / m1_resp_vld_o  out  1  response valid, routed
m0_resp_r_data_o / m1_resp_r_data_o  out  32  read data (broadcast of s_resp_r_data_i)
m0_resp_err_o / m1_resp_err_o  out  1  error (broadcast of s_resp_err_i)
s_req_vld_o  out  1  request to TCM
s_req_rdy_i  in  1  TCM ready
s_req_addr_o / s_req_w_en_o / s_req_w_be_o / s_req_w_data_o  out  32/1/4/32  muxed request fields
s_resp_vld_i  in  1  TCM response valid
s_resp_r_data_i  in  32  TCM read data
s_resp_err_i  in  1  TCM error
proto_err_o  out  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset (rst_i high at posedge): occupancy=0, FIFO pointers=0, last_grant=1 (m0 wins first tie), proto_err_o=0. All *_vld_o/*_rdy_o are 0 while rst_i is high; registered outputs are 0 in the first cycle after reset.
- Grant (combinational): can_issue = s_req_rdy_i & (occupancy != outst_depth_p). Only one master valid -> that master. Both valid -> master != last_grant.
- s_req_vld_o = (m0_req_vld_i | m1_req_vld_i) & (occupancy != outst_depth_p). Request fields are muxed from the granted master and are zero when neither is valid.
- mX_req_rdy_o = grant==X & can_issue. Acceptance happens when vld & rdy are both high in the same cycle. No combinational path from mX_req_rdy_o to mX_req_vld_i.
- On acceptance: push the master ID (1 bit) into the FIFO and update last_grant to that ID (registered).
- Response routing: when s_resp_vld_i is high and the FIFO is non-empty, pop the head ID and drive m<ID>_resp_vld_o=1 in the same cycle (combinational, zero added latency). Data and err are passed straight through.
- Full: the grant is withheld when occupancy==outst_depth_p, even if a pop occurs the same cycle (no bypass). Full-cycle throughput is still sustained with a 1-cycle-latency TCM whenever outst_depth_p>=2.
- Empty + s_resp_vld_i: the response is dropped (no mX_resp_vld_o), occupancy stays 0, and proto_err_o is set until reset.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. Pointers wrap modulo outst_depth_p.
- Fairness: a master holding vld is granted within 2 accepted transactions.
- Reset mid-operation: outstanding IDs are discarded. Any TCM responses arriving after reset count as proto_err events; the integration must quiesce the TCM or reset it together with this block.
- Writes also produce one response each, matching the TCM's behaviour of one resp_vld per accepted request.

Optional Feature:
XRV1_TCM_ARB_PERF_EN.
- Defined: adds outputs perf_m0_grants_o (32), perf_m1_grants_o (32) and perf_stall_o (32).
  - perf_m0_grants_o / perf_m1_grants_o increment on each accepted request from that master.
  - perf_stall_o increments on every cycle in which some mX_req_vld_i is high but that master's rdy is low.
  - All three counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset check: hold rst_i for 3 cycles with both vld high -> all rdy/vld outputs stay 0; after release, m0 is granted first; proto_err_o=0.
- Both masters stream reads (m0 addr 0x100.., m1 addr 0x200..) with s_req_rdy_i=1 and a 1-cycle TCM -> grants alternate m0,m1,m0,m1; each mX_resp_vld_o fires exactly once per accepted request, 1 cycle later, carrying the data for its own address.
- Single master: m1 writes 0xDEADBEEF to 0x40 with be=4'b0011 while m0 is idle -> m1 is granted back-to-back each cycle; m1_resp_vld_o=1 one cycle later; m0_resp_vld_o never fires.
- Backpressure and full, outst_depth_p=4, TCM stalls responses 6 cycles -> exactly 4 acceptances, then rdy stays low until the first response; the 5th request is accepted in the cycle after that response.
- Spurious response: pulse s_resp_vld_i with nothing outstanding -> no mX_resp_vld_o; proto_err_o rises next cycle and stays 1 until reset.
- With XRV1_TCM_ARB_PERF_EN defined: 10 m0 requests and 6 m1 requests with 3 stall cycles -> counters read 10 / 6 / 3.

Source files
------------

// File: rtl/xrv1_tcm_arb.sv
// xrv1_tcm_arb
// Two-master arbiter for the simulation TCM data port. The core LSU (m0) and
// the debug/program loader (m1) share one request channel under round-robin
// grant. An in-order ID FIFO steers each TCM response back to its issuer.
// The response path adds no latency.
// Optional build macro: XRV1_TCM_ARB_PERF_EN adds grant and stall counters.
module xrv1_tcm_arb #(
    parameter int outst_depth_p = 4,
    localparam int outst_cnt_width_lp = $clog2(outst_depth_p + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_vld_i,
    output logic        m0_req_rdy_o,
    input  logic [31:0] m0_req_addr_i,
    input  logic        m0_req_w_en_i,
    input  logic [3:0]  m0_req_w_be_i,
    input  logic [31:0] m0_req_w_data_i,
    output logic        m0_resp_vld_o,
    output logic [31:0] m0_resp_r_data_o,
    output logic        m0_resp_err_o,

    input  logic        m1_req_vld_i,
    output logic        m1_req_rdy_o,
    input  logic [31:0] m1_req_addr_i,
    input  logic        m1_req_w_en_i,
    input  logic [3:0]  m1_req_w_be_i,
    input  logic [31:0] m1_req_w_data_i,
    output logic        m1_resp_vld_o,
    output logic [31:0] m1_resp_r_data_o,
    output logic        m1_resp_err_o,

    output logic        s_req_vld_o,
    input  logic        s_req_rdy_i,
    output logic [31:0] s_req_addr_o,
    output logic        s_req_w_en_o,
    output logic [3:0]  s_req_w_be_o,
    output logic [31:0] s_req_w_data_o,
    input  logic        s_resp_vld_i,
    input  logic [31:0] s_resp_r_data_i,
    input  logic        s_resp_err_i,

`ifdef XRV1_TCM_ARB_PERF_EN
    output logic [31:0] perf_m0_grants_o,
    output logic [31:0] perf_m1_grants_o,
    output logic [31:0] perf_stall_o,
`endif

    output logic        proto_err_o
);

    localparam int ptr_width_lp = (outst_depth_p > 1) ? $clog2(outst_depth_p) : 1;
    localparam logic [outst_cnt_width_lp-1:0] occ_full_lp  = outst_cnt_width_lp'(outst_depth_p);
    localparam logic [outst_cnt_width_lp-1:0] occ_zero_lp  = {outst_cnt_width_lp{1'b0}};
    localparam logic [outst_cnt_width_lp-1:0] occ_one_lp   = outst_cnt_width_lp'(1);
    localparam logic [ptr_width_lp-1:0]       ptr_zero_lp  = {ptr_width_lp{1'b0}};
    localparam logic [ptr_width_lp-1:0]       ptr_last_lp  = ptr_width_lp'(outst_depth_p - 1);

    // Pointer advance with explicit wrap at the last FIFO slot.
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
        logic [ptr_width_lp-1:0] nxt;
        if (ptr == ptr_last_lp) begin
            nxt = ptr_zero_lp;
        end else begin
            nxt = ptr + ptr_width_lp'(1);
        end
        return nxt;
    endfunction

    logic                          last_grant_r;
    logic [outst_cnt_width_lp-1:0] occ_r;
    logic [ptr_width_lp-1:0]       wr_ptr_r;
    logic [ptr_width_lp-1:0]       rd_ptr_r;
    logic                          id_mem_r [outst_depth_p];
    logic                          proto_err_r;

    logic any_vld_s;
    logic full_s;
    logic empty_s;
    logic can_issue_s;
    logic grant_id_s;
    logic s_req_vld_s;
    logic accept_s;
    logic pop_s;
    logic spurious_s;
    logic head_id_s;

    assign any_vld_s   = m0_req_vld_i | m1_req_vld_i;
    assign full_s      = (occ_r == occ_full_lp);
    assign empty_s     = (occ_r == occ_zero_lp);
    // No pop bypass: a full FIFO blocks the grant even if a response retires now.
    assign can_issue_s = s_req_rdy_i & ~full_s & ~rst_i;
    assign s_req_vld_s = any_vld_s & ~full_s & ~rst_i;
    assign accept_s    = s_req_vld_s & s_req_rdy_i;
    assign pop_s       = s_resp_vld_i & ~empty_s & ~rst_i;
    assign spurious_s  = s_resp_vld_i & empty_s & ~rst_i;
    assign head_id_s   = id_mem_r[rd_ptr_r];

    assign s_req_vld_o  = s_req_vld_s;
    assign m0_req_rdy_o = ~grant_id_s & can_issue_s;
    assign m1_req_rdy_o = grant_id_s & can_issue_s;

    assign m0_resp_vld_o    = pop_s & ~head_id_s;
    assign m1_resp_vld_o    = pop_s & head_id_s;
    assign m0_resp_r_data_o = s_resp_r_data_i;
    assign m1_resp_r_data_o = s_resp_r_data_i;
    assign m0_resp_err_o    = s_resp_err_i;
    assign m1_resp_err_o    = s_resp_err_i;
    assign proto_err_o      = proto_err_r;

    // Round-robin grant: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        grant_id_s = 1'b0;
        if (m0_req_vld_i && m1_req_vld_i) begin
            grant_id_s = ~last_grant_r;
        end else if (m1_req_vld_i) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Request field mux from the granted master; fields idle at zero with no requester.
    always_comb begin
        s_req_addr_o   = 32'h0000_0000;
        s_req_w_en_o   = 1'b0;
        s_req_w_be_o   = 4'h0;
        s_req_w_data_o = 32'h0000_0000;
        if (!any_vld_s) begin
            s_req_addr_o   = 32'h0000_0000;
            s_req_w_en_o   = 1'b0;
            s_req_w_be_o   = 4'h0;
            s_req_w_data_o = 32'h0000_0000;
        end else if (grant_id_s) begin
            s_req_addr_o   = m1_req_addr_i;
            s_req_w_en_o   = m1_req_w_en_i;
            s_req_w_be_o   = m1_req_w_be_i;
            s_req_w_data_o = m1_req_w_data_i;
        end else begin
            s_req_addr_o   = m0_req_addr_i;
            s_req_w_en_o   = m0_req_w_en_i;
            s_req_w_be_o   = m0_req_w_be_i;
            s_req_w_data_o = m0_req_w_data_i;
        end
    end

    // Remember the last accepted master so the next tie flips to the other one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Outstanding-request occupancy: push on accept, pop on routed response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_r <= occ_zero_lp;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + occ_one_lp;
                2'b01:   occ_r <= occ_r - occ_one_lp;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // ID FIFO pointers; both advance on a simultaneous push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= ptr_zero_lp;
            rd_ptr_r <= ptr_zero_lp;
        end else begin
            wr_ptr_r <= accept_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        end
    end

    // ID FIFO storage; contents are cleared so the head never reads unknown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < outst_depth_p; i++) begin
                id_mem_r[i] <= 1'b0;
            end
        end else if (accept_s) begin
            id_mem_r[wr_ptr_r] <= grant_id_s;
        end else begin
            id_mem_r[wr_ptr_r] <= id_mem_r[wr_ptr_r];
        end
    end

    // Sticky protocol error: a response arrived with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_r <= 1'b0;
        end else if (spurious_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

`ifdef XRV1_TCM_ARB_PERF_EN
    logic        stall_s;
    logic [31:0] perf_m0_grants_r;
    logic [31:0] perf_m1_grants_r;
    logic [31:0] perf_stall_r;

    assign stall_s = (m0_req_vld_i & ~m0_req_rdy_o) | (m1_req_vld_i & ~m1_req_rdy_o);

    assign perf_m0_grants_o = perf_m0_grants_r;
    assign perf_m1_grants_o = perf_m1_grants_r;
    assign perf_stall_o     = perf_stall_r;

    // Free-running wrap-around counters for accepted grants and stalled cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_m0_grants_r <= 32'h0000_0000;
            perf_m1_grants_r <= 32'h0000_0000;
            perf_stall_r     <= 32'h0000_0000;
        end else begin
            perf_m0_grants_r <= perf_m0_grants_r + {31'h0, accept_s & ~grant_id_s};
            perf_m1_grants_r <= perf_m1_grants_r + {31'h0, accept_s & grant_id_s};
            perf_stall_r     <= perf_stall_r + {31'h0, stall_s};
        end
    end
`endif

endmodule

// File: tb/tb_xrv1_tcm_arb.sv
// Directed bench for xrv1_tcm_arb with a small in-order TCM response model.
module tb_xrv1_tcm_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_vld_i, m0_req_rdy_o, m0_req_w_en_i, m0_resp_vld_o, m0_resp_err_o;
    logic [31:0] m0_req_addr_i, m0_req_w_data_i, m0_resp_r_data_o;
    logic [3:0]  m0_req_w_be_i;
    logic        m1_req_vld_i, m1_req_rdy_o, m1_req_w_en_i, m1_resp_vld_o, m1_resp_err_o;
    logic [31:0] m1_req_addr_i, m1_req_w_data_i, m1_resp_r_data_o;
    logic [3:0]  m1_req_w_be_i;
    logic        s_req_vld_o, s_req_rdy_i, s_req_w_en_o;
    logic [31:0] s_req_addr_o, s_req_w_data_o;
    logic [3:0]  s_req_w_be_o;
    logic        s_resp_vld_i, s_resp_err_i;
    logic [31:0] s_resp_r_data_i;
    logic        proto_err_o;
`ifdef XRV1_TCM_ARB_PERF_EN
    logic [31:0] perf_m0_grants_o, perf_m1_grants_o, perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    xrv1_tcm_arb #(.outst_depth_p(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_vld_i(m0_req_vld_i), .m0_req_rdy_o(m0_req_rdy_o), .m0_req_addr_i(m0_req_addr_i),
        .m0_req_w_en_i(m0_req_w_en_i), .m0_req_w_be_i(m0_req_w_be_i), .m0_req_w_data_i(m0_req_w_data_i),
        .m0_resp_vld_o(m0_resp_vld_o), .m0_resp_r_data_o(m0_resp_r_data_o), .m0_resp_err_o(m0_resp_err_o),
        .m1_req_vld_i(m1_req_vld_i), .m1_req_rdy_o(m1_req_rdy_o), .m1_req_addr_i(m1_req_addr_i),
        .m1_req_w_en_i(m1_req_w_en_i), .m1_req_w_be_i(m1_req_w_be_i), .m1_req_w_data_i(m1_req_w_data_i),
        .m1_resp_vld_o(m1_resp_vld_o), .m1_resp_r_data_o(m1_resp_r_data_o), .m1_resp_err_o(m1_resp_err_o),
        .s_req_vld_o(s_req_vld_o), .s_req_rdy_i(s_req_rdy_i), .s_req_addr_o(s_req_addr_o),
        .s_req_w_en_o(s_req_w_en_o), .s_req_w_be_o(s_req_w_be_o), .s_req_w_data_o(s_req_w_data_o),
        .s_resp_vld_i(s_resp_vld_i), .s_resp_r_data_i(s_resp_r_data_i), .s_resp_err_i(s_resp_err_i),
`ifdef XRV1_TCM_ARB_PERF_EN
        .perf_m0_grants_o(perf_m0_grants_o), .perf_m1_grants_o(perf_m1_grants_o),
        .perf_stall_o(perf_stall_o),
`endif
        .proto_err_o(proto_err_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t tq[$];
    int   cyc = 0;
    int   lat = 1;
    logic force_resp = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    // Values sampled mid-cycle by tick()
    logic        c_m0_rdy, c_m1_rdy, c_m0_rv, c_m1_rv, c_m0_err, c_svld, c_wen, c_perr;
    logic [31:0] c_m0_rd, c_m1_rd, c_saddr, c_wdata;
    logic [3:0]  c_wbe;

    function automatic logic [31:0] tcm_data(input logic [31:0] addr);
        return {addr[15:0], 16'hC0DE};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive TCM response at negedge, sample, update model, return after posedge.
    task automatic tick();
        @(negedge clk_i);
        if (force_resp) begin
            s_resp_vld_i = 1'b1; s_resp_r_data_i = 32'h0BAD_0BAD; s_resp_err_i = 1'b1;
        end else if (tq.size() > 0 && tq[0].due <= cyc) begin
            s_resp_vld_i = 1'b1; s_resp_r_data_i = tq[0].data; s_resp_err_i = tq[0].err;
        end else begin
            s_resp_vld_i = 1'b0; s_resp_r_data_i = 32'h0; s_resp_err_i = 1'b0;
        end
        #1;
        c_m0_rdy = m0_req_rdy_o; c_m1_rdy = m1_req_rdy_o;
        c_m0_rv  = m0_resp_vld_o; c_m1_rv = m1_resp_vld_o;
        c_m0_rd  = m0_resp_r_data_o; c_m1_rd = m1_resp_r_data_o; c_m0_err = m0_resp_err_o;
        c_svld   = s_req_vld_o; c_saddr = s_req_addr_o; c_wen = s_req_w_en_o;
        c_wbe    = s_req_w_be_o; c_wdata = s_req_w_data_o; c_perr = proto_err_o;
        if (s_resp_vld_i && !force_resp) void'(tq.pop_front());
        if (s_req_vld_o && s_req_rdy_i)
            tq.push_back('{tcm_data(s_req_addr_o), s_req_addr_o[3], cyc + lat});
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_addr, prev_addr;
        int          n_rv0, n_rv1;

        rst_i = 1'b1; s_req_rdy_i = 1'b1;
        s_resp_vld_i = 1'b0; s_resp_r_data_i = 32'h0; s_resp_err_i = 1'b0;
        m0_req_vld_i = 1'b1; m0_req_addr_i = 32'h100; m0_req_w_en_i = 1'b0;
        m0_req_w_be_i = 4'hF; m0_req_w_data_i = 32'h1234_5678;
        m1_req_vld_i = 1'b1; m1_req_addr_i = 32'h200; m1_req_w_en_i = 1'b0;
        m1_req_w_be_i = 4'hF; m1_req_w_data_i = 32'h0;

        // Reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_rdy0", 32'(c_m0_rdy), 32'd0);
            check_val("rst_rdy1", 32'(c_m1_rdy), 32'd0);
            check_val("rst_svld", 32'(c_svld), 32'd0);
            check_val("rst_rv", 32'({c_m0_rv, c_m1_rv}), 32'd0);
        end
        rst_i = 1'b0;

        // Both masters stream reads: grants alternate starting with m0
        for (int i = 0; i < 8; i++) begin
            m0_req_addr_i = 32'h100 + 32'(4 * ((i + 1) / 2));
            m1_req_addr_i = 32'h200 + 32'(4 * (i / 2));
            tick();
            exp_addr = (i % 2 == 0) ? 32'h100 + 32'(4 * (i / 2)) : 32'h200 + 32'(4 * (i / 2));
            if (i == 0) check_val("rel_perr", 32'(c_perr), 32'd0);
            check_val("st_rdy0", 32'(c_m0_rdy), 32'(i % 2 == 0));
            check_val("st_rdy1", 32'(c_m1_rdy), 32'(i % 2 == 1));
            check_val("st_addr", c_saddr, exp_addr);
            if (i == 0) begin
                check_val("st_rv_first", 32'({c_m0_rv, c_m1_rv}), 32'd0);
            end else begin
                prev_addr = ((i - 1) % 2 == 0) ? 32'h100 + 32'(4 * ((i - 1) / 2))
                                               : 32'h200 + 32'(4 * ((i - 1) / 2));
                check_val("st_rv0", 32'(c_m0_rv), 32'((i - 1) % 2 == 0));
                check_val("st_rv1", 32'(c_m1_rv), 32'((i - 1) % 2 == 1));
                check_val("st_rdata", ((i - 1) % 2 == 0) ? c_m0_rd : c_m1_rd, tcm_data(prev_addr));
                check_val("st_err", 32'(c_m0_err), 32'(prev_addr[3]));
            end
        end
        m0_req_vld_i = 1'b0; m1_req_vld_i = 1'b0;
        tick();
        check_val("st_last_rv1", 32'(c_m1_rv), 32'd1);
        check_val("st_last_rv0", 32'(c_m0_rv), 32'd0);
        check_val("st_last_data", c_m1_rd, 32'h020C_C0DE);
        check_val("idle_addr_zero", c_saddr, 32'd0);

        // m1 alone writes back-to-back
        m1_req_vld_i = 1'b1; m1_req_addr_i = 32'h40; m1_req_w_en_i = 1'b1;
        m1_req_w_be_i = 4'b0011; m1_req_w_data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("wr_rdy1", 32'(c_m1_rdy), 32'd1);
            check_val("wr_addr", c_saddr, 32'h40);
            check_val("wr_fields", {27'd0, c_wen, c_wbe}, 32'h13);
            check_val("wr_data", c_wdata, 32'hDEAD_BEEF);
            check_val("wr_rv1", 32'(c_m1_rv), 32'(i > 0));
            check_val("wr_rv0", 32'(c_m0_rv), 32'd0);
        end
        m1_req_vld_i = 1'b0; m1_req_w_en_i = 1'b0;
        tick();
        check_val("wr_drain_rv1", 32'(c_m1_rv), 32'd1);
        check_val("wr_drain_rv0", 32'(c_m0_rv), 32'd0);

        // Full FIFO with a 6-cycle TCM: four accepts, stall, fifth accept after first response
        lat = 6; n_rv0 = 0; n_rv1 = 0;
        m0_req_vld_i = 1'b1;
        for (int t = 0; t < 8; t++) begin
            m0_req_addr_i = 32'h300 + 32'(4 * ((t < 4) ? t : 4));
            tick();
            check_val("full_rdy0", 32'(c_m0_rdy), 32'(t < 4 || t == 7));
            check_val("full_svld", 32'(c_svld), 32'(t < 4 || t == 7));
            if (t == 5) check_val("full_no_early_rv", 32'(c_m0_rv), 32'd0);
            if (t == 6) begin
                check_val("full_first_rv", 32'(c_m0_rv), 32'd1);
                check_val("full_first_data", c_m0_rd, 32'h0300_C0DE);
            end
            n_rv0 += int'(c_m0_rv); n_rv1 += int'(c_m1_rv);
        end
        m0_req_vld_i = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_rv0 += int'(c_m0_rv); n_rv1 += int'(c_m1_rv);
        end
        check_val("full_rv0_count", 32'(n_rv0), 32'd5);
        check_val("full_rv1_count", 32'(n_rv1), 32'd0);
        lat = 1;

        // Spurious response with nothing outstanding
        force_resp = 1'b1;
        tick();
        check_val("sp_rv", 32'({c_m0_rv, c_m1_rv}), 32'd0);
        check_val("sp_perr_same", 32'(c_perr), 32'd0);
        check_val("sp_err_bcast", 32'(c_m0_err), 32'd1);
        force_resp = 1'b0;
        tick();
        check_val("sp_perr_next", 32'(c_perr), 32'd1);
        tick();
        check_val("sp_perr_sticky", 32'(c_perr), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        check_val("sp_perr_cleared", 32'(c_perr), 32'd0);

`ifdef XRV1_TCM_ARB_PERF_EN
        // Counters: 10 m0 grants, 6 m1 grants, 3 stall cycles
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m0_req_vld_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m0_req_addr_i = 32'h500 + 32'(4 * i);
            tick();
        end
        m0_req_vld_i = 1'b0; m1_req_vld_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m1_req_addr_i = 32'h600 + 32'(4 * i);
            tick();
        end
        m1_req_vld_i = 1'b0; m0_req_vld_i = 1'b1; s_req_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        m0_req_vld_i = 1'b0; s_req_rdy_i = 1'b1;
        tick();
        tick();
        check_val("perf_m0", perf_m0_grants_o, 32'd10);
        check_val("perf_m1", perf_m1_grants_o, 32'd6);
        check_val("perf_stall", perf_stall_o, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
